// File: rtl/pipelined_cla_addsub.sv
// Pipelined carry-lookahead adder/subtractor: one BLOCK_W-bit lookahead block per stage,
// block carry registered between stages, valid/ready handshake with whole-pipe stall.
module pipelined_cla_addsub #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned BLOCK_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_carry,
    output logic             out_overflow,
    output logic             out_zero
);

    localparam int unsigned N = WIDTH / BLOCK_W;

    // Every carry is a flat OR of generate terms plus the propagated carry-in; no carry
    // depends on another computed carry.
    function automatic logic [BLOCK_W:0] cla_carries(input logic [BLOCK_W-1:0] g,
                                                     input logic [BLOCK_W-1:0] p,
                                                     input logic               cin);
        logic [BLOCK_W:0] c;
        logic             term;
        c    = '0;
        c[0] = cin;
        for (int i = 0; i < int'(BLOCK_W); i++) begin
            term = cin;
            for (int m = 0; m <= i; m++) begin
                term = term & p[m];
            end
            c[i+1] = term;
            for (int j = 0; j <= i; j++) begin
                term = g[j];
                for (int m = j + 1; m <= i; m++) begin
                    term = term & p[m];
                end
                c[i+1] = c[i+1] | term;
            end
        end
        return c;
    endfunction

    // Stage outputs: w holds result bits below the processed block and operand A above it.
    logic             v_s [N];
    logic             c_s [N];
    logic [WIDTH-1:0] w_s [N];
    logic [WIDTH-1:0] b_s [N];

    logic             advance;
    logic [WIDTH-1:0] b_in;
    logic             ovf_q;
    logic             zero_q;

    assign advance  = !v_s[N-1] || out_ready;
    assign in_ready = advance && !reset;
    assign b_in     = in_sub ? ~in_b : in_b;

    for (genvar k = 0; k < int'(N); k++) begin : g_stage
        localparam int unsigned Lo = k * BLOCK_W;

        logic               v_i;
        logic               c_i;
        logic [WIDTH-1:0]   w_i;
        logic [WIDTH-1:0]   b_i;
        logic [BLOCK_W-1:0] a_sl;
        logic [BLOCK_W-1:0] b_sl;
        logic [BLOCK_W-1:0] gen;
        logic [BLOCK_W-1:0] prop;
        logic [BLOCK_W:0]   cy;
        logic [WIDTH-1:0]   w_d;
        logic               v_q;
        logic               c_q;
        logic [WIDTH-1:0]   w_q;
        logic [WIDTH-1:0]   b_q;

        if (k == 0) begin : g_first
            assign v_i = in_valid;
            assign c_i = in_sub;
            assign w_i = in_a;
            assign b_i = b_in;
        end else begin : g_next
            assign v_i = v_s[k-1];
            assign c_i = c_s[k-1];
            assign w_i = w_s[k-1];
            assign b_i = b_s[k-1];
        end

        always_comb begin
            a_sl             = w_i[Lo +: BLOCK_W];
            b_sl             = b_i[Lo +: BLOCK_W];
            gen              = a_sl & b_sl;
            prop             = a_sl ^ b_sl;
            cy               = cla_carries(gen, prop, c_i);
            w_d              = w_i;
            w_d[Lo +: BLOCK_W] = prop ^ cy[BLOCK_W-1:0];
        end

        // Data registers only load real beats so the output holds its last value when idle.
        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                v_q <= 1'b0;
                c_q <= 1'b0;
                w_q <= '0;
                b_q <= '0;
            end else if (advance) begin
                v_q <= v_i;
                if (v_i) begin
                    c_q <= cy[BLOCK_W];
                    w_q <= w_d;
                    b_q <= b_i;
                end
            end
        end

        assign v_s[k] = v_q;
        assign c_s[k] = c_q;
        assign w_s[k] = w_q;
        assign b_s[k] = b_q;

        if (k == int'(N) - 1) begin : g_flags
            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    ovf_q  <= 1'b0;
                    zero_q <= 1'b0;
                end else if (advance && v_i) begin
                    ovf_q  <= cy[BLOCK_W] ^ cy[BLOCK_W-1];
                    zero_q <= ~|w_d;
                end
            end
        end
    end

    assign out_valid    = v_s[N-1];
    assign out_sum      = w_s[N-1];
    assign out_carry    = c_s[N-1];
    assign out_overflow = ovf_q;
    assign out_zero     = zero_q;

endmodule

// File: tb/tb_pipelined_cla_addsub.sv
// Bench for pipelined_cla_addsub: a 32/8 and a 16/4 instance checked against an
// arithmetic model through per-DUT expectation queues, plus literal spot checks.
module tb_pipelined_cla_addsub;

    typedef struct packed {
        logic [31:0] sum;
        logic        c;
        logic        o;
        logic        z;
    } res_t;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid  [2];
    logic        in_sub    [2];
    logic        out_ready [2];
    logic [31:0] in_a      [2];
    logic [31:0] in_b      [2];
    logic        in_ready  [2];
    logic        out_valid [2];
    logic        out_carry [2];
    logic        out_ovf   [2];
    logic        out_zero  [2];
    logic [31:0] out_sum   [2];

    logic        r0, v0, c0, o0, z0, r1, v1, c1, o1, z1;
    logic [31:0] s0;
    logic [15:0] s1;

    int   vecs = 0;
    int   errs = 0;
    res_t q0[$];
    res_t q1[$];

    always #5 clock = ~clock;

    pipelined_cla_addsub #(.WIDTH(32), .BLOCK_W(8)) u_dut32 (
        .clock(clock), .reset(reset),
        .in_valid(in_valid[0]), .in_ready(r0), .in_a(in_a[0]), .in_b(in_b[0]),
        .in_sub(in_sub[0]), .out_valid(v0), .out_ready(out_ready[0]), .out_sum(s0),
        .out_carry(c0), .out_overflow(o0), .out_zero(z0)
    );

    pipelined_cla_addsub #(.WIDTH(16), .BLOCK_W(4)) u_dut16 (
        .clock(clock), .reset(reset),
        .in_valid(in_valid[1]), .in_ready(r1), .in_a(in_a[1][15:0]), .in_b(in_b[1][15:0]),
        .in_sub(in_sub[1]), .out_valid(v1), .out_ready(out_ready[1]), .out_sum(s1),
        .out_carry(c1), .out_overflow(o1), .out_zero(z1)
    );

    assign in_ready[0]  = r0;
    assign in_ready[1]  = r1;
    assign out_valid[0] = v0;
    assign out_valid[1] = v1;
    assign out_sum[0]   = s0;
    assign out_sum[1]   = {16'h0, s1};
    assign out_carry[0] = c0;
    assign out_carry[1] = c1;
    assign out_ovf[0]   = o0;
    assign out_ovf[1]   = o1;
    assign out_zero[0]  = z0;
    assign out_zero[1]  = z1;

    function automatic int wof(int d);
        return (d == 0) ? 32 : 16;
    endfunction

    // Plain integer arithmetic: unsigned result mod 2^w, carry = unsigned overflow or
    // no-borrow, overflow = signed result out of range.
    function automatic res_t model(int w, logic [31:0] a, logic [31:0] b, logic sub);
        longint m, ua, ub, sa, sb, sr;
        res_t   r;
        m  = longint'(1) << w;
        ua = longint'({32'd0, a}) & (m - 1);
        ub = longint'({32'd0, b}) & (m - 1);
        sa = (ua >= m / 2) ? ua - m : ua;
        sb = (ub >= m / 2) ? ub - m : ub;
        if (sub) begin
            r.c   = (ua >= ub);
            sr    = sa - sb;
            r.sum = 32'((ua - ub) & (m - 1));
        end else begin
            r.c   = ((ua + ub) >= m);
            sr    = sa + sb;
            r.sum = 32'((ua + ub) & (m - 1));
        end
        r.o = (sr >= m / 2) || (sr < -(m / 2));
        r.z = (r.sum == 32'd0);
        return r;
    endfunction

    function automatic logic [31:0] pick(int w);
        logic [31:0] r;
        case ($urandom_range(0, 7))
            0:       r = 32'd0;
            1:       r = 32'd1;
            2:       r = '1;
            3:       r = 32'd1 << (w - 1);
            4:       r = (32'd1 << (w - 1)) - 32'd1;
            default: r = $urandom;
        endcase
        if (w < 32) r = r & ((32'd1 << w) - 32'd1);
        return r;
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic res_t cur_out(int d);
        return {out_sum[d], out_carry[d], out_ovf[d], out_zero[d]};
    endfunction

    // Compare process: every result handed over must match the oldest pending beat.
    res_t hold    [2];
    logic stalled [2] = '{1'b0, 1'b0};
    always @(negedge clock) begin
        for (int d = 0; d < 2; d++) begin
            if (reset) begin
                stalled[d] = 1'b0;
            end else begin
                res_t cur, e;
                int   n;
                cur = cur_out(d);
                check($sformatf("in_ready rule d%0d", d), 64'(in_ready[d]),
                      64'(!out_valid[d] || out_ready[d]));
                if (stalled[d]) begin
                    check($sformatf("stall hold d%0d", d), {cur, out_valid[d]}, {hold[d], 1'b1});
                end
                stalled[d] = out_valid[d] && !out_ready[d];
                hold[d]    = cur;
                if (out_valid[d] && out_ready[d]) begin
                    n = (d == 0) ? q0.size() : q1.size();
                    if (n == 0) begin
                        vecs++;
                        errs++;
                        $display("FAIL spurious result d%0d: got %h with none pending, expected no out_valid",
                                 d, cur);
                    end else begin
                        e = (d == 0) ? q0.pop_front() : q1.pop_front();
                        check($sformatf("result d%0d", d), cur, e);
                    end
                end
                if (in_valid[d] && in_ready[d]) begin
                    e = model(wof(d), in_a[d], in_b[d], in_sub[d]);
                    if (d == 0) q0.push_back(e);
                    else        q1.push_back(e);
                end
            end
        end
    end

    task automatic one(int d, logic [31:0] a, logic [31:0] b, logic sub,
                       logic [31:0] es, logic ec, logic eo, logic ez);
        res_t lit;
        int   lat;
        lit = {es, ec, eo, ez};
        check($sformatf("model d%0d %h%s%h", d, a, sub ? "-" : "+", b), model(wof(d), a, b, sub), lit);
        in_a[d] = a; in_b[d] = b; in_sub[d] = sub; in_valid[d] = 1'b1; out_ready[d] = 1'b1;
        @(posedge clock); #1;
        in_valid[d] = 1'b0;
        lat = 1;
        while (!out_valid[d] && lat < 20) begin
            @(posedge clock); #1;
            lat++;
        end
        check($sformatf("latency d%0d", d), 64'(lat), 64'd4);
        check($sformatf("literal d%0d %h%s%h", d, a, sub ? "-" : "+", b), cur_out(d), lit);
        @(posedge clock); #1;
    endtask

    task automatic backpressure();
        int i     = 0;
        int stall = 0;
        bit seen  = 0;
        bit acc;
        out_ready[0] = 1'b1;
        for (int cyc = 0; cyc < 25; cyc++) begin
            in_valid[0] = (i < 6);
            in_a[0]     = 32'h1111_1111 * i + 32'h0F0F_0F0F;
            in_b[0]     = ~(32'h0101_0101 * i);
            in_sub[0]   = i[0];
            if (!seen && out_valid[0]) begin
                seen  = 1;
                stall = 3;
            end
            out_ready[0] = (stall == 0);
            if (stall > 0) stall--;
            @(negedge clock);
            acc = in_valid[0] && in_ready[0];
            @(posedge clock); #1;
            if (acc) i++;
        end
        in_valid[0] = 1'b0;
        check("bp beats accepted", 64'(i), 64'd6);
        check("bp all delivered", 64'(q0.size()), 64'd0);
    endtask

    task automatic rst_mid(int d);
        out_ready[d] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid[d] = 1'b1; in_a[d] = pick(wof(d)); in_b[d] = pick(wof(d));
            in_sub[d] = 1'($urandom_range(0, 1));
            @(posedge clock); #1;
        end
        in_valid[d] = 1'b0;
        check($sformatf("pre-reset valid d%0d", d), 64'(out_valid[d]), 64'd1);
        #2 reset = 1'b1;
        #1;
        check($sformatf("reset outputs d%0d", d),
              {cur_out(d), out_valid[d], in_ready[d]}, 64'd0);
        q0.delete();
        q1.delete();
        repeat (2) @(posedge clock);
        #3 reset = 1'b0;
        #1;
        check($sformatf("in_ready after release d%0d", d), 64'(in_ready[d]), 64'd1);
        for (int i = 0; i < 8; i++) begin
            @(posedge clock); #1;
            check($sformatf("no stale beat d%0d", d), 64'(out_valid[d]), 64'd0);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int d = 0; d < 2; d++) begin
            in_valid[d] = 1'b0; in_sub[d] = 1'b0; out_ready[d] = 1'b0;
            in_a[d] = '0; in_b[d] = '0;
        end
        #1 reset = 1'b1;
        #1;
        for (int d = 0; d < 2; d++) begin
            check($sformatf("reset state d%0d", d), {cur_out(d), out_valid[d], in_ready[d]}, 64'd0);
        end
        #20 reset = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            check($sformatf("first ready d%0d", d), 64'(in_ready[d]), 64'd1);
        end
        @(posedge clock); #1;

        one(0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
        one(0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
        one(0, 32'h0000_0005, 32'h0000_0007, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
        one(0, 32'h0000_0007, 32'h0000_0005, 1'b1, 32'h0000_0002, 1'b1, 1'b0, 1'b0);
        one(0, 32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
        one(1, 32'h0000_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
        one(1, 32'h0000_8000, 32'h0000_0001, 1'b1, 32'h0000_7FFF, 1'b1, 1'b1, 1'b0);
        one(1, 32'h0000_0005, 32'h0000_0007, 1'b1, 32'h0000_FFFE, 1'b0, 1'b0, 1'b0);

        backpressure();

        for (int n = 0; n < 400; n++) begin
            for (int d = 0; d < 2; d++) begin
                in_valid[d]  = ($urandom_range(0, 3) != 0);
                in_a[d]      = pick(wof(d));
                in_b[d]      = pick(wof(d));
                in_sub[d]    = 1'($urandom_range(0, 1));
                out_ready[d] = ($urandom_range(0, 9) < 7);
            end
            @(posedge clock); #1;
        end
        for (int d = 0; d < 2; d++) begin
            in_valid[d]  = 1'b0;
            out_ready[d] = 1'b1;
        end
        repeat (12) @(posedge clock);
        #1;
        check("drain d0", 64'(q0.size()), 64'd0);
        check("drain d1", 64'(q1.size()), 64'd0);

        rst_mid(0);
        rst_mid(1);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/pipelined_cla_addsub.md
Name: pipelined_cla_addsub

Overview:
- Parametrised, pipelined carry-lookahead adder/subtractor; next generation of the 32-bit single-cycle CLA adder.
- Splits a WIDTH-bit operation into BLOCK_W-bit lookahead blocks, with one block per pipeline stage and the carry registered between stages.
- Adds a subtract mode, carry-out, zero flag, and valid/ready handshakes on both sides.
- Sits between the ALU operand latch and writeback in the processor datapath.

Parameters:
- WIDTH, 32, operand/result width in bits; must be an integer multiple of BLOCK_W.
- BLOCK_W, 8, bits per lookahead block. Number of stages N = WIDTH/BLOCK_W, and N must be at least 1.

Ports:
- clock  input  1  sole clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  block can accept a beat this cycle.
- in_a  input  WIDTH  operand A.
- in_b  input  WIDTH  operand B.
- in_sub  input  1  0 = A+B; 1 = A-B.
- out_valid  output  1  result beat valid.
- out_ready  input  1  consumer accepts the result this cycle.
- out_sum  output  WIDTH  result, modulo 2^WIDTH.
- out_carry  output  1  carry out of the MSB. For subtraction, 1 means no borrow.
- out_overflow  output  1  signed (two's-complement) overflow.
- out_zero  output  1  out_sum == 0.

Behaviour:
- Reset (asynchronous, active-high):
  - All stage valid bits, skew registers and output registers clear immediately to 0.
  - While reset is asserted: out_valid=0, out_sum=0, out_carry=0, out_overflow=0, out_zero=0, in_ready=0.
  - in_ready=1 on the first cycle after deassertion.
- Subtract mode: B is bitwise inverted and the stage-0 carry-in is 1. Otherwise B passes through and carry-in is 0.
- Stage k (0..N-1):
  - Computes bits [k*BLOCK_W +: BLOCK_W] using a full lookahead within the block (g=a&b, p=a^b, carries from group generate/propagate; no ripple).
  - Takes its carry-in from the stage k-1 carry register.
  - Upper operand slices travel in skew registers.
  - Lower result slices are carried forward so the full sum emerges aligned.
- Latency: a beat accepted at rising edge t produces out_valid=1 after edge t+N-1, i.e. N cycles; for default parameters N=4.
- Throughput: one beat per cycle when not stalled. Bubbles (in_valid=0) propagate as invalid stages.
- Stall and backpressure:
  - advance = !out_valid || out_ready.
  - in_ready = advance, combinational from out_valid/out_ready.
  - All stages move together only when advance=1.
  - When advance=0, every register holds its value, no beat is accepted, and out_* stay stable.
- Transfer rules:
  - Input transfer: in_valid && in_ready.
  - Output transfer: out_valid && out_ready.
  - Simultaneous output consume and input accept in the same cycle is legal.
  - Order is strictly preserved; no beat is dropped or duplicated.
- Flags (from the final stage):
  - out_carry = carry out of bit WIDTH-1.
  - out_overflow = carry into MSB XOR carry out of MSB.
  - out_zero = ~|out_sum.
- Idle hold: when out_valid=0 after a consume, the output data registers keep their last value; consumers ignore them.
- Reset mid-operation: all in-flight beats are discarded; none emerge after reset is released.
- N=1 (BLOCK_W=WIDTH): single registered stage, latency 1, same handshake rules.

Test Plan:
- Reset: assert reset asynchronously between edges -> out_valid=0 and all out_* = 0 immediately; in_ready=1 on the first cycle after release.
- 0x7FFFFFFF + 0x00000001, sub=0 -> 4 cycles later: out_sum=0x80000000, overflow=1, carry=0, zero=0.
- Full carry chain, 0xFFFFFFFF + 0x00000001 -> out_sum=0, carry=1, zero=1, overflow=0.
- Subtraction:
  - 5 - 7 -> 0xFFFFFFFE, carry=0, overflow=0.
  - 7 - 5 -> 0x00000002, carry=1.
  - 0x80000000 - 1 -> 0x7FFFFFFF, overflow=1.
- Backpressure: stream 6 beats back-to-back; hold out_ready=0 for 3 cycles once the first result appears -> in_ready=0 during the stall, out_* stable, all 6 results in order with no loss.
- Reset mid-stream with 3 beats in flight -> out_valid drops at once; no stale result appears after release. Repeat with WIDTH=16, BLOCK_W=4 -> latency 4; 0xFFFF + 1 gives sum=0, carry=1.
